// File: rtl/reg_bus_arbiter_if.sv
// rtl/reg_bus_arbiter_if.sv - peripheral-side and reg_bank-side signals of the register bus arbiter
interface reg_bus_arbiter_if #(
  parameter int REG_WIDTH = 8,
  parameter int ADDR_W    = 8
);
  logic                 a_req;
  logic                 a_wr_rdn;
  logic [ADDR_W-1:0]    a_addr;
  logic [REG_WIDTH-1:0] a_wdata;
  logic                 a_ack;
  logic                 a_err;
  logic [REG_WIDTH-1:0] a_rdata;
  logic                 a_ovr;

  logic                 b_req;
  logic                 b_wr_rdn;
  logic [ADDR_W-1:0]    b_addr;
  logic [REG_WIDTH-1:0] b_wdata;
  logic                 b_ack;
  logic                 b_err;
  logic [REG_WIDTH-1:0] b_rdata;
  logic                 b_ovr;

  logic                 ovr_clr;

  logic                 m_we;
  logic                 m_re;
  logic                 m_wr_rdn;
  logic [ADDR_W-1:0]    m_addr;
  logic [REG_WIDTH-1:0] m_wdata;
  logic [REG_WIDTH-1:0] m_rdata;
  logic                 m_ack;

  logic                 busy;

  // arbiter view
  modport slave (
    input  a_req, a_wr_rdn, a_addr, a_wdata,
    output a_ack, a_err, a_rdata, a_ovr,
    input  b_req, b_wr_rdn, b_addr, b_wdata,
    output b_ack, b_err, b_rdata, b_ovr,
    input  ovr_clr,
    output m_we, m_re, m_wr_rdn, m_addr, m_wdata,
    input  m_rdata, m_ack,
    output busy
  );

  // peripherals and reg_bank view
  modport master (
    output a_req, a_wr_rdn, a_addr, a_wdata,
    input  a_ack, a_err, a_rdata, a_ovr,
    output b_req, b_wr_rdn, b_addr, b_wdata,
    input  b_ack, b_err, b_rdata, b_ovr,
    output ovr_clr,
    input  m_we, m_re, m_wr_rdn, m_addr, m_wdata,
    output m_rdata, m_ack,
    input  busy
  );
endinterface

// File: rtl/reg_bus_arbiter.sv
// rtl/reg_bus_arbiter.sv - two-port register bus arbiter with round-robin grant and timeout
module reg_bus_arbiter #(
  parameter int REG_WIDTH = 8,
  parameter int ADDR_W    = 8,
  parameter int TIMEOUT   = 15
) (
  input logic              clk,
  input logic              rst,
  reg_bus_arbiter_if.slave bus
);

  // counter runs 0..TIMEOUT-1 inside WAIT; reaching the last value without m_ack times out
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t state, state_next;

  logic                 a_pend, b_pend;
  logic                 a_slot_wr, b_slot_wr;
  logic [ADDR_W-1:0]    a_slot_addr, b_slot_addr;
  logic [REG_WIDTH-1:0] a_slot_wdata, b_slot_wdata;
  logic                 a_ovr_reg, b_ovr_reg;

  logic                 grant_b;
  logic                 rr_b;
  logic [CNT_W-1:0]     cnt;

  logic                 issue_wr;
  logic [ADDR_W-1:0]    issue_addr;
  logic [REG_WIDTH-1:0] issue_wdata;

  logic                 a_ack_reg, b_ack_reg, a_err_reg, b_err_reg;
  logic [REG_WIDTH-1:0] a_rdata_reg, b_rdata_reg;

  logic                 take_grant, pick_b, finish, timed_out;
  logic                 a_clr, b_clr, a_load, b_load;

  // a slot is freed in RESP; a same-port request in that cycle refills it instead of overrunning
  assign a_clr  = (state == RESP) && !grant_b;
  assign b_clr  = (state == RESP) && grant_b;
  assign a_load = bus.a_req && (!a_pend || a_clr);
  assign b_load = bus.b_req && (!b_pend || b_clr);

  // next state, grant choice and completion status
  always_comb begin
    state_next = state;
    take_grant = 1'b0;
    pick_b     = 1'b0;
    finish     = 1'b0;
    timed_out  = 1'b0;
    case (state)
      IDLE: begin
        if (a_pend || b_pend) begin
          take_grant = 1'b1;
          pick_b     = b_pend && (!a_pend || rr_b);
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.m_ack) begin
          finish     = 1'b1;
          state_next = RESP;
        end else begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (bus.m_ack) begin
          finish     = 1'b1;
          state_next = RESP;
        end else if (cnt == CNT_LAST) begin
          finish     = 1'b1;
          timed_out  = 1'b1;
          state_next = RESP;
        end
      end
      RESP: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM state, timeout counter, round-robin pointer and downstream access fields
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      rr_b        <= 1'b0;
      grant_b     <= 1'b0;
      issue_wr    <= 1'b0;
      issue_addr  <= '0;
      issue_wdata <= '0;
    end else begin
      state <= state_next;
      if (state == ISSUE) cnt <= '0;
      else if (state == WAIT) cnt <= cnt + 1'b1;
      if (state == RESP) rr_b <= !grant_b;
      if (take_grant) begin
        grant_b     <= pick_b;
        issue_wr    <= pick_b ? b_slot_wr    : a_slot_wr;
        issue_addr  <= pick_b ? b_slot_addr  : a_slot_addr;
        issue_wdata <= pick_b ? b_slot_wdata : a_slot_wdata;
      end
    end
  end

  // per-port pending slots and sticky overrun flags (set beats clear)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_pend       <= 1'b0;
      b_pend       <= 1'b0;
      a_slot_wr    <= 1'b0;
      b_slot_wr    <= 1'b0;
      a_slot_addr  <= '0;
      b_slot_addr  <= '0;
      a_slot_wdata <= '0;
      b_slot_wdata <= '0;
      a_ovr_reg    <= 1'b0;
      b_ovr_reg    <= 1'b0;
    end else begin
      if (a_load) begin
        a_pend       <= 1'b1;
        a_slot_wr    <= bus.a_wr_rdn;
        a_slot_addr  <= bus.a_addr;
        a_slot_wdata <= bus.a_wdata;
      end else if (a_clr) begin
        a_pend <= 1'b0;
      end
      if (b_load) begin
        b_pend       <= 1'b1;
        b_slot_wr    <= bus.b_wr_rdn;
        b_slot_addr  <= bus.b_addr;
        b_slot_wdata <= bus.b_wdata;
      end else if (b_clr) begin
        b_pend <= 1'b0;
      end
      if (bus.a_req && a_pend && !a_clr) a_ovr_reg <= 1'b1;
      else if (bus.ovr_clr) a_ovr_reg <= 1'b0;
      if (bus.b_req && b_pend && !b_clr) b_ovr_reg <= 1'b1;
      else if (bus.ovr_clr) b_ovr_reg <= 1'b0;
    end
  end

  // completion pulse, error flag and read data, all valid during the RESP cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_ack_reg   <= 1'b0;
      b_ack_reg   <= 1'b0;
      a_err_reg   <= 1'b0;
      b_err_reg   <= 1'b0;
      a_rdata_reg <= '0;
      b_rdata_reg <= '0;
    end else begin
      a_ack_reg <= finish && !grant_b;
      b_ack_reg <= finish && grant_b;
      a_err_reg <= finish && !grant_b && timed_out;
      b_err_reg <= finish && grant_b && timed_out;
      if (finish && !grant_b) begin
        if (timed_out) a_rdata_reg <= '0;
        else if (!issue_wr) a_rdata_reg <= bus.m_rdata;
      end
      if (finish && grant_b) begin
        if (timed_out) b_rdata_reg <= '0;
        else if (!issue_wr) b_rdata_reg <= bus.m_rdata;
      end
    end
  end

  assign bus.a_ack    = a_ack_reg;
  assign bus.b_ack    = b_ack_reg;
  assign bus.a_err    = a_err_reg;
  assign bus.b_err    = b_err_reg;
  assign bus.a_rdata  = a_rdata_reg;
  assign bus.b_rdata  = b_rdata_reg;
  assign bus.a_ovr    = a_ovr_reg;
  assign bus.b_ovr    = b_ovr_reg;
  assign bus.m_we     = (state == ISSUE) && issue_wr;
  assign bus.m_re     = (state == ISSUE) && !issue_wr;
  assign bus.m_wr_rdn = issue_wr;
  assign bus.m_addr   = issue_addr;
  assign bus.m_wdata  = issue_wdata;
  assign bus.busy     = (state != IDLE);

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// tb/tb_reg_bus_arbiter.sv - self-checking bench for reg_bus_arbiter
module tb_reg_bus_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  reg_bus_arbiter_if #(.REG_WIDTH(8), .ADDR_W(8)) bus ();

  reg_bus_arbiter #(.REG_WIDTH(8), .ADDR_W(8), .TIMEOUT(15)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic       ar, aw;
    logic [7:0] aa;
    logic       br, bw;
    logic [7:0] ba;
    logic       mk;
    logic [7:0] mrd;
    logic       clr;
    logic [8:0] fl;
    logic [7:0] maddr, ard, brd;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle_inputs();
    bus.a_req = 0; bus.a_wr_rdn = 0; bus.a_addr = 0; bus.a_wdata = 0;
    bus.b_req = 0; bus.b_wr_rdn = 0; bus.b_addr = 0; bus.b_wdata = 0;
    bus.m_ack = 0; bus.m_rdata = 0; bus.ovr_clr = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic v(input logic ar, aw, input logic [7:0] aa, input logic br, bw,
                   input logic [7:0] ba, input logic mk, input logic [7:0] mrd, input logic clr,
                   input logic [8:0] fl, input logic [7:0] maddr, ard, brd);
    tbl.push_back('{ar, aw, aa, br, bw, ba, mk, mrd, clr, fl, maddr, ard, brd});
  endtask

  function automatic logic [8:0] flags();
    return {bus.busy, bus.m_we, bus.m_re, bus.a_ack, bus.a_err, bus.b_ack, bus.b_err, bus.a_ovr, bus.b_ovr};
  endfunction

  // random-phase model state
  bit         out_p[2];
  bit         r_wr[2];
  logic [7:0] r_addr[2], r_wd[2];
  int         r_cyc[2];
  logic [7:0] mdl_rd[2];
  bit         inflight;
  int         fl_p, bank_cyc, ack_cyc, last_served, t0, strobes, noise;
  logic [7:0] bank_rd;

  initial begin
    idle_inputs();
    // flags: {busy, m_we, m_re, a_ack, a_err, b_ack, b_err, a_ovr, b_ovr}
    //  ar aw aa     br bw ba     mk mrd    clr flags          maddr  ard    brd
    v(1, 1, 8'h10, 1, 1, 8'h20, 0, 8'h00, 0, 9'b000000000, 8'h00, 8'h00, 8'h00); // both write, reset state
    v(0, 0, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0, 9'b000000000, 8'h00, 8'h00, 8'h00);
    v(0, 0, 8'h00, 0, 0, 8'h00, 1, 8'h00, 0, 9'b110000000, 8'h10, 8'h00, 8'h00); // a first
    v(0, 0, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0, 9'b100100000, 8'h10, 8'h00, 8'h00);
    v(0, 0, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0, 9'b000000000, 8'h10, 8'h00, 8'h00);
    v(0, 0, 8'h00, 0, 0, 8'h00, 1, 8'h00, 0, 9'b110000000, 8'h20, 8'h00, 8'h00); // then b
    v(0, 0, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0, 9'b100001000, 8'h20, 8'h00, 8'h00);
    v(1, 1, 8'h11, 1, 1, 8'h21, 0, 8'h00, 0, 9'b000000000, 8'h20, 8'h00, 8'h00); // third round
    v(0, 0, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0, 9'b000000000, 8'h20, 8'h00, 8'h00);
    v(0, 0, 8'h00, 0, 0, 8'h00, 1, 8'h00, 0, 9'b110000000, 8'h11, 8'h00, 8'h00);
    v(0, 0, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0, 9'b100100000, 8'h11, 8'h00, 8'h00);
    v(0, 0, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0, 9'b000000000, 8'h11, 8'h00, 8'h00);
    v(0, 0, 8'h00, 0, 0, 8'h00, 1, 8'h00, 0, 9'b110000000, 8'h21, 8'h00, 8'h00);
    v(0, 0, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0, 9'b100001000, 8'h21, 8'h00, 8'h00);
    v(1, 0, 8'h03, 0, 0, 8'h00, 0, 8'h00, 0, 9'b000000000, 8'h21, 8'h00, 8'h00); // a read 0x03
    v(0, 0, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0, 9'b000000000, 8'h21, 8'h00, 8'h00);
    v(0, 0, 8'h00, 0, 0, 8'h00, 1, 8'h5A, 0, 9'b101000000, 8'h03, 8'h00, 8'h00);
    v(0, 0, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0, 9'b100100000, 8'h03, 8'h5A, 8'h00);
    v(1, 1, 8'h40, 0, 0, 8'h00, 0, 8'h00, 0, 9'b000000000, 8'h03, 8'h5A, 8'h00); // a overrun
    v(1, 1, 8'h41, 0, 0, 8'h00, 0, 8'h00, 0, 9'b000000000, 8'h03, 8'h5A, 8'h00);
    v(0, 0, 8'h00, 0, 0, 8'h00, 1, 8'h00, 0, 9'b110000010, 8'h40, 8'h5A, 8'h00);
    v(0, 0, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0, 9'b100100010, 8'h40, 8'h5A, 8'h00);
    v(0, 0, 8'h00, 0, 0, 8'h00, 0, 8'h00, 1, 9'b000000010, 8'h40, 8'h5A, 8'h00);
    v(0, 0, 8'h00, 1, 0, 8'h50, 0, 8'h00, 0, 9'b000000000, 8'h40, 8'h5A, 8'h00); // b overrun vs clr
    v(0, 0, 8'h00, 1, 0, 8'h51, 0, 8'h00, 1, 9'b000000000, 8'h40, 8'h5A, 8'h00);
    v(0, 0, 8'h00, 0, 0, 8'h00, 1, 8'h77, 0, 9'b101000001, 8'h50, 8'h5A, 8'h00);
    v(0, 0, 8'h00, 1, 1, 8'h60, 0, 8'h00, 0, 9'b100001001, 8'h50, 8'h5A, 8'h77); // req in RESP
    v(0, 0, 8'h00, 0, 0, 8'h00, 0, 8'h00, 1, 9'b000000001, 8'h50, 8'h5A, 8'h77);
    v(0, 0, 8'h00, 0, 0, 8'h00, 1, 8'h99, 0, 9'b110000000, 8'h60, 8'h5A, 8'h77);
    v(0, 0, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0, 9'b100001000, 8'h60, 8'h5A, 8'h77);
    v(0, 0, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0, 9'b000000000, 8'h60, 8'h5A, 8'h77);

    do_reset();
    foreach (tbl[i]) begin
      chk($sformatf("vec%0d_flags", i), 64'(flags()), 64'(tbl[i].fl));
      chk($sformatf("vec%0d_maddr", i), 64'(bus.m_addr), 64'(tbl[i].maddr));
      chk($sformatf("vec%0d_rdata", i), 64'({bus.a_rdata, bus.b_rdata}), 64'({tbl[i].ard, tbl[i].brd}));
      bus.a_req = tbl[i].ar; bus.a_wr_rdn = tbl[i].aw; bus.a_addr = tbl[i].aa; bus.a_wdata = tbl[i].aa ^ 8'hC3;
      bus.b_req = tbl[i].br; bus.b_wr_rdn = tbl[i].bw; bus.b_addr = tbl[i].ba; bus.b_wdata = tbl[i].ba ^ 8'h3C;
      bus.m_ack = tbl[i].mk; bus.m_rdata = tbl[i].mrd; bus.ovr_clr = tbl[i].clr;
      step();
    end
    idle_inputs();

    // timeout: b read with no m_ack -> error completion after 15 WAIT cycles
    t0 = cyc;
    bus.b_req = 1; bus.b_wr_rdn = 0; bus.b_addr = 8'h33;
    step();
    idle_inputs();
    step();
    chk("tmo_strobe", 64'({bus.m_re, bus.m_we, bus.m_addr}), 64'({1'b1, 1'b0, 8'h33}));
    strobes = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (bus.m_we || bus.m_re) strobes++;
      if (bus.b_ack) break;
    end
    chk("tmo_ack_cycle", 64'(cyc - t0), 64'd18);
    chk("tmo_wait_strobes", 64'(strobes), 64'd0);
    chk("tmo_resp", 64'({bus.b_ack, bus.b_err, bus.b_rdata, bus.a_ack}), 64'({1'b1, 1'b1, 8'h00, 1'b0}));
    step();
    chk("tmo_idle", 64'({bus.busy, bus.b_ack, bus.b_err}), 64'd0);

    // reset during WAIT
    bus.a_req = 1; bus.a_wr_rdn = 1; bus.a_addr = 8'h44; bus.a_wdata = 8'hEE;
    step();
    idle_inputs();
    step();
    step();
    step();
    chk("rst_pre_wait", 64'({bus.busy, bus.m_we, bus.m_addr}), 64'({1'b1, 1'b0, 8'h44}));
    rst = 1'b1;
    #1;
    chk("rst_flags", 64'(flags()), 64'd0);
    chk("rst_fields", 64'({bus.m_wr_rdn, bus.m_addr, bus.m_wdata, bus.a_rdata, bus.b_rdata}), 64'd0);
    step();
    rst = 1'b0;
    strobes = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (bus.a_ack || bus.m_we || bus.m_re || bus.busy) strobes++;
    end
    chk("rst_quiet", 64'(strobes), 64'd0);

    // randomized traffic against a transaction-level model
    do_reset();
    for (int p = 0; p < 2; p++) begin out_p[p] = 0; mdl_rd[p] = 0; end
    inflight = 0; last_served = 1; noise = 0;
    for (int n = 0; n < 3000; n++) begin
      if (bus.m_we || bus.m_re) begin
        bit ea, eb;
        int p;
        ea = out_p[0] && r_cyc[0] <= cyc - 2;
        eb = out_p[1] && r_cyc[1] <= cyc - 2;
        p = (ea && eb) ? 1 - last_served : (eb ? 1 : 0);
        if (inflight || !(ea || eb)) chk("rnd_strobe_legal", 64'({inflight, ea, eb}), 64'({1'b0, 1'b1, 1'b1}));
        else begin
          chk("rnd_strobe", 64'({bus.m_we, bus.m_re, bus.m_addr, bus.m_wdata}),
              64'({r_wr[p], !r_wr[p], r_addr[p], r_wd[p]}));
          inflight = 1; fl_p = p;
          bank_cyc = cyc + int'($urandom_range(0, 4));
          ack_cyc  = bank_cyc + 1;
          bank_rd  = 8'($urandom);
        end
      end
      if (bus.a_ack || bus.b_ack) begin
        if (!inflight) chk("rnd_ack_expected", 64'({bus.a_ack, bus.b_ack}), 64'd0);
        else begin
          if (!r_wr[fl_p]) mdl_rd[fl_p] = bank_rd;
          chk("rnd_ack_cycle", 64'(cyc), 64'(ack_cyc));
          chk("rnd_ack", 64'({bus.a_ack, bus.b_ack, bus.a_err, bus.b_err, bus.a_rdata, bus.b_rdata}),
              64'({fl_p == 0, fl_p == 1, 2'b00, mdl_rd[0], mdl_rd[1]}));
          out_p[fl_p] = 0; inflight = 0; last_served = fl_p;
        end
      end else if (inflight && cyc >= ack_cyc) begin
        chk("rnd_ack_timeout", 64'd0, 64'd1);
        out_p[fl_p] = 0; inflight = 0;
      end
      bus.m_ack   = inflight ? (cyc == bank_cyc) : ($urandom_range(0, 7) == 0);
      bus.m_rdata = (inflight && cyc == bank_cyc) ? bank_rd : 8'($urandom);
      bus.ovr_clr = ($urandom_range(0, 15) == 0);
      bus.a_req = 0; bus.a_wr_rdn = 1'($urandom); bus.a_addr = 8'($urandom); bus.a_wdata = 8'($urandom);
      bus.b_req = 0; bus.b_wr_rdn = 1'($urandom); bus.b_addr = 8'($urandom); bus.b_wdata = 8'($urandom);
      if (n < 2950) begin
        if (!out_p[0] && $urandom_range(0, 2) == 0) begin
          bus.a_req = 1; out_p[0] = 1; r_cyc[0] = cyc;
          r_wr[0] = bus.a_wr_rdn; r_addr[0] = bus.a_addr; r_wd[0] = bus.a_wdata;
        end
        if (!out_p[1] && $urandom_range(0, 2) == 0) begin
          bus.b_req = 1; out_p[1] = 1; r_cyc[1] = cyc;
          r_wr[1] = bus.b_wr_rdn; r_addr[1] = bus.b_addr; r_wd[1] = bus.b_wdata;
        end
      end
      step();
    end
    idle_inputs();
    chk("rnd_drained", 64'({out_p[0], out_p[1], inflight, bus.busy}), 64'd0);
    chk("rnd_no_ovr", 64'({bus.a_ovr, bus.b_ovr}), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_bus_arbiter.md
REG_BUS_ARBITER -- requirements
Module: reg_bus_arbiter

Interface
REQ-001 SHALL have parameter REG_WIDTH, default 8, data width.
REQ-002 SHALL have parameter ADDR_W, default 8, address width.
REQ-003 SHALL have parameter TIMEOUT, default 15, the maximum number of WAIT cycles before an error completion.
REQ-004 SHALL have port clk, input, 1, the single clock; all state is updated on its rising edge.
REQ-005 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-006 SHALL have ports a_req / b_req, input, 1, single-cycle request strobes (a = SPI peripheral, b = I2C peripheral).
REQ-007 SHALL have ports a_wr_rdn / b_wr_rdn, input, 1, access direction (1 = write); sampled with req.
REQ-008 SHALL have ports a_addr / b_addr, input, ADDR_W, address; sampled with req.
REQ-009 SHALL have ports a_wdata / b_wdata, input, REG_WIDTH, write data; sampled with req.
REQ-010 SHALL have ports a_ack / b_ack, output, 1, one-cycle completion pulse.
REQ-011 SHALL have ports a_err / b_err, output, 1, timeout flag; valid with ack.
REQ-012 SHALL have ports a_rdata / b_rdata, output, REG_WIDTH, registered read data.
REQ-013 SHALL have ports a_ovr / b_ovr, output, 1, sticky overrun flag.
REQ-014 SHALL have port ovr_clr, input, 1, clears both ovr flags.
REQ-015 SHALL have ports m_we / m_re, output, 1, one-cycle write/read strobes to reg_bank.
REQ-016 SHALL have ports m_wr_rdn, m_addr, m_wdata, output, 1/ADDR_W/REG_WIDTH, downstream access fields.
REQ-017 SHALL have ports m_rdata, m_ack, input, REG_WIDTH/1, downstream read data and completion.
REQ-018 SHALL have port busy, output, 1, high whenever the FSM is not in IDLE.

Function
REQ-019 SHALL hold a one-deep pending slot per port (pend flag, wr_rdn, addr, wdata), loaded on the edge that samples req=1 while pend=0.
REQ-020 SHALL drop a request arriving while its port's pend=1 (except REQ-029), keep the original slot contents, and set that port's ovr.
REQ-021 SHALL clear ovr on ovr_clr; if a new overrun occurs in the same cycle, set wins.
REQ-022 SHALL implement FSM states IDLE, ISSUE, WAIT and RESP.
REQ-023 IDLE: if any pend=1, the FSM SHALL latch the grant and go to ISSUE; otherwise it stays in IDLE.
REQ-024 Grant: a single pending port SHALL win; if both are pending, the port selected by the round-robin pointer rr SHALL win (reset value rr = a).
REQ-025 ISSUE: the FSM SHALL assert exactly one of m_we (write) or m_re (read) for one cycle, drive m_* from the granted slot, go to RESP if m_ack=1 in the same cycle, and otherwise go to WAIT.
REQ-026 WAIT: the FSM SHALL keep m_* fields stable with strobes low and increment the timeout counter each cycle.
REQ-027 WAIT: on m_ack=1 the FSM SHALL go to RESP; when the counter reaches TIMEOUT without m_ack, it SHALL go to RESP with an error.
REQ-028 RESP: the FSM SHALL pulse the granted port's ack for one cycle, drive err as the error status, and load rdata with m_rdata for a successful read (0 on error; unchanged on a write).
REQ-029 RESP SHALL also clear the granted pend, set rr to the other port, and return to IDLE; a same-port req in the RESP cycle SHALL be captured as a new pending request (set wins, no overrun).
REQ-030 SHALL ignore m_ack outside ISSUE and WAIT.
REQ-031 SHALL hold m_addr, m_wdata and m_wr_rdn at their last values outside a transaction.
REQ-032 Minimum latency: with req at cycle 0, the strobe SHALL occur at cycle 2 and ack at cycle 3 (same-cycle m_ack); back-to-back service of both ports SHALL alternate.

Reset
REQ-033 Reset SHALL force: FSM to IDLE; pend, ovr, ack, err, m_we, m_re and busy to 0; rdata and m_* fields to 0; rr to a; the timeout counter to 0.
REQ-034 Reset asserted mid-transaction SHALL abort the transaction with no ack and no strobe on any following cycle.

Verification
REQ-035 Read test: a_req read addr 0x03 at cycle 0, m_ack + m_rdata=0x5A in ISSUE -> m_re at cycle 2, a_ack at cycle 3, a_rdata=0x5A, a_err=0.
REQ-036 Contention test: a_req and b_req in the same cycle (both writes) after reset -> a served first, then b, each producing one m_we; a third round with both pending serves a first again.
REQ-037 Timeout test: m_ack held 0 -> RESP after 15 WAIT cycles, b_ack=1 with b_err=1 and b_rdata=0x00, then the FSM returns to IDLE.
REQ-038 Overrun test: a second a_req while a is pending (not in RESP) -> a_ovr=1, the original addr is served, and ovr_clr returns a_ovr to 0.
REQ-039 Reset test: rst pulsed during WAIT -> busy=0, no a_ack, and all outputs at reset values.
